// File: rtl/data_memory_sync_if.sv
// Request/response bus between the Y86-64 memory stage (master) and the
// clocked data memory (slave).
interface data_memory_sync_if #(
    parameter int unsigned DATA_W = 64
);
    logic                  mem_req;
    logic                  mem_ready;
    logic                  mem_read;
    logic                  mem_write;
    logic [63:0]           mem_addr;
    logic [DATA_W-1:0]     M_valA;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_done;
    logic [DATA_W-1:0]     mem_data;
    logic                  dmem_error;

    modport master (
        output mem_req, mem_read, mem_write, mem_addr, M_valA, mem_wstrb,
        input  mem_ready, mem_done, mem_data, dmem_error
    );

    modport slave (
        input  mem_req, mem_read, mem_write, mem_addr, M_valA, mem_wstrb,
        output mem_ready, mem_done, mem_data, dmem_error
    );
endinterface

// File: rtl/data_memory_sync.sv
// Clocked data memory with request/ready handshake, programmable access
// latency, byte-strobed writes and registered error status.
module data_memory_sync #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned DEPTH   = 8192,
    parameter int unsigned LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_memory_sync_if.slave    bus
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned BW = $clog2(NB);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                req_read;
    logic                req_write;
    logic [63:0]         req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [NB-1:0]       req_wstrb;
    logic                ready_q;
    logic                done_q;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [AW-1:0]       idx;
    logic                misaligned;
    logic                out_of_range;
    logic                req_err;
    logic                access;
    logic                do_write;

    // Full 64-bit range compare so high address bits never alias into the array.
    assign idx          = req_addr[BW +: AW];
    assign misaligned   = (req_addr & 64'(NB - 1)) != 64'd0;
    assign out_of_range = (req_addr >> (BW + AW)) != 64'd0;
    assign req_err      = misaligned | out_of_range | (req_read == req_write);
    assign access       = (state == WAIT) && (cnt == 4'd0);
    assign do_write     = access && req_write && !req_err;

    assign bus.mem_ready  = ready_q;
    assign bus.mem_done   = done_q;
    assign bus.mem_data   = data_q;
    assign bus.dmem_error = err_q;

    // NOTE: state and output registers use non-blocking assignments so every
    // register sees the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_read  <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= 64'd0;
            req_wdata <= '0;
            req_wstrb <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (bus.mem_req) begin
                        req_read  <= bus.mem_read;
                        req_write <= bus.mem_write;
                        req_addr  <= bus.mem_addr;
                        req_wdata <= bus.M_valA;
                        req_wstrb <= bus.mem_wstrb;
                        cnt       <= 4'(LATENCY - 1);
                        ready_q   <= 1'b0;
                        state     <= WAIT;
                    end else begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        err_q   <= req_err;
                        data_q  <= (req_read && !req_err) ? mem[idx] : '0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= RESP;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // NOTE: the array has no reset; a reset during WAIT forces state to IDLE
    // asynchronously, which drops do_write and aborts the pending write.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < NB; i++) begin
                if (req_wstrb[i]) mem[idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
            end
        end
    end
endmodule

// File: doc/data_memory_sync.md
# data_memory_sync

Clocked, parametrised data memory for the Y86-64 memory stage. Replaces the combinational array with a request/ready handshake, a configurable access latency, byte-strobed writes and registered error detection. Errors cover misalignment, out-of-range addresses and illegal command encodings. The memory stage issues one request at a time. It stalls on `mem_ready` and consumes `mem_data` and `dmem_error` on `mem_done`; a `dmem_error` maps to status SADR upstream.

## Interface

- `DATA_W`, default 64: word width in bits; power of two, ≥ 8.
- `DEPTH`, default 8192: number of words; power of two.
- `LATENCY`, default 1: cycles from request acceptance to the access edge; range 1..15.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `mem_req`  in  1: request valid.
- `mem_ready`  out  1: the block can accept a request this cycle.
- `mem_read`  in  1: the request is a read.
- `mem_write`  in  1: the request is a write.
- `mem_addr`  in  64: byte address.
- `M_valA`  in  DATA_W: write data.
- `mem_wstrb`  in  DATA_W/8: write byte enables; bit i controls byte i (little-endian).
- `mem_done`  out  1: one-cycle pulse marking request completion.
- `mem_data`  out  DATA_W: read data; valid while `mem_done` = 1.
- `dmem_error`  out  1: error status of the completed request; valid while `mem_done` = 1.

## Operation

- **Definitions:**
  - BW = log2(DATA_W/8).
  - Word index = `mem_addr` >> BW.
  - Array: DEPTH × DATA_W. Contents are not reset and are uninitialised after power-up.
- **States:**
  - IDLE and RESP: `mem_ready` = 1.
  - WAIT: `mem_ready` = 0.
- **Acceptance:** a request is accepted on an edge where `mem_req` & `mem_ready` = 1.
  - The latched copy holds `mem_read`, `mem_write`, `mem_addr`, `M_valA` and `mem_wstrb`.
  - The state moves to WAIT and the counter loads LATENCY-1.
  - Inputs are ignored in WAIT.
- **WAIT:**
  - Counter > 0: decrement.
  - Counter = 0: perform the access on this edge, then go to RESP.
- **RESP:** lasts exactly one cycle, with `mem_done` = 1.
  - If `mem_req` = 1 in RESP, accept the new request (→ WAIT).
  - Otherwise → IDLE.
- **Error conditions** (evaluated on the latched request); any true sets `dmem_error` = 1:
  - `mem_addr`[BW-1:0] ≠ 0 (misaligned).
  - Word index ≥ DEPTH (out of range; all 64 address bits are compared, with no truncation or wrap).
  - `mem_read` = `mem_write` = 1.
  - `mem_read` = `mem_write` = 0.
- **Errored request:** array unmodified, `mem_data` = 0.
- **Read:** `mem_data` = array[index], sampled at the access edge.
- **Write:** array[index] byte i ← `M_valA` byte i where `mem_wstrb`[i] = 1; other bytes are kept. `mem_data` = 0.
- **Output hold:**
  - `mem_data` and `dmem_error` hold their values until the next access edge.
  - Consumers sample them only while `mem_done` = 1.

## Timing

- **Reset values:** state IDLE, counter 0, `mem_ready` = 1, `mem_done` = 0, `mem_data` = 0, `dmem_error` = 0.
- **Reset assertion mid-WAIT:** the request is aborted and no write occurs.
- **Write at the reset edge:** a write whose access edge coincides with `rst_n` falling is not guaranteed.
- **Latency:** request accepted at edge e0 → access at edge e0+LATENCY → `mem_done` high during cycle (e0+LATENCY, e0+LATENCY+1).
- **Throughput:** back-to-back accepts from RESP give one completion every LATENCY+1 cycles.
- **Read after write:** a read accepted in the RESP cycle of a write to the same word returns the new data.
- **Handshake:** `mem_ready` and `mem_done` are registered outputs; there is no combinational path from inputs to outputs.
- **Requester rule:** the requester must hold the request fields stable only in the acceptance cycle.

## Test plan

- **Basic write/read, LATENCY = 1:** write 0x0123456789ABCDEF to 0x40 with strobe 0xFF, then read 0x40.
  - Each request: `mem_done` 2 cycles after `mem_req` is raised in IDLE.
  - Read returns 0x0123456789ABCDEF, `dmem_error` = 0.
- **Byte strobe:** write 0xFFFF…FF to 0x40 with `mem_wstrb` = 0x0F, then read 0x40.
  - Word preloaded 0x0123456789ABCDEF → read returns 0x01234567FFFFFFFF.
- **Misaligned write:** write to 0x43.
  - `dmem_error` = 1 with `mem_done`.
  - A subsequent read of 0x40 is unchanged.
- **Out of range / illegal commands:**
  - Read of 0x10000 (word 8192) → `dmem_error` = 1, `mem_data` = 0.
  - `mem_read` = `mem_write` = 1 → `dmem_error` = 1.
  - Neither set → `dmem_error` = 1.
- **LATENCY = 4, back-to-back:** issue 3 reads with `mem_req` held high.
  - `mem_done` pulses at cycles 5, 10 and 15 after the first accept.
  - `mem_ready` = 0 during every WAIT.
- **Reset mid-operation, LATENCY = 4:** write 0xAA…AA to 0x80, assert `rst_n` = 0 two cycles after accept.
  - Outputs return to reset values immediately.
  - After release, a read of 0x80 returns its pre-write contents.
